int_ctrl: RTL and testbench
===========================

INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 Parameter VEC_BASE, default 32'h0000_0100: base address of the interrupt handler vector table.
REQ-002 Parameter NSRC, fixed 4: number of interrupt sources; the cause encoding is 2 bits wide.
REQ-003 Clk  in  1  single clock; all state updates on posedge Clk.
REQ-004 Rst  in  1  synchronous, active-high reset, sampled on posedge Clk.
REQ-005 irq  in  4  level interrupt request lines; bit 0 has the highest priority.
REQ-006 int_en  in  1  global interrupt enable.
REQ-007 stall  in  1  pipeline stall; blocks acceptance of an interrupt.
REQ-008 pc_cur  in  32  resume PC presented by the fetch stage.
REQ-009 eret  in  1  handler-return instruction retired, valid for one cycle.
REQ-010 INT_Detect  out  1  one-cycle pulse to every stage register: save and zero contents.
REQ-011 INT_Return  out  1  one-cycle pulse to every stage register: restore saved contents.
REQ-012 pc_redirect  out  1  one-cycle pulse: fetch loads pc_target.
REQ-013 pc_target  out  32  redirect address.
REQ-014 epc  out  32  saved resume PC.
REQ-015 int_cause  out  2  index of the source being serviced.
REQ-016 in_service  out  1  high while the handler is active.

Function
REQ-017 Edge capture: irq_prev is a registered copy of irq; pending[i] is set on any cycle where irq[i]=1 and irq_prev[i]=0.
REQ-018 Pending bits are sticky; pending[i] is cleared only when source i is accepted or on reset.
REQ-019 If a new edge on source i and the acceptance of source i occur in the same cycle, the set wins and pending[i] stays 1.
REQ-020 FSM states: IDLE, DETECT, SERVICE, RETURN; all outputs are decoded from registered state and registers only.
REQ-021 IDLE->DETECT when pending!=0, int_en=1 and stall=0.
REQ-022 On that transition: int_cause <= lowest set pending index; epc <= pc_cur; the accepted pending bit is cleared.
REQ-023 Otherwise the FSM stays in IDLE; eret is ignored in IDLE.
REQ-024 DETECT lasts exactly 1 cycle: INT_Detect=1, pc_redirect=1, pc_target=VEC_BASE+{int_cause,4'b0000}; next state is SERVICE.
REQ-025 SERVICE: in_service=1 and INT_Detect/INT_Return/pc_redirect=0.
REQ-026 SERVICE: new edges still set pending bits but are not accepted (no nesting); int_en and stall have no effect.
REQ-027 SERVICE->RETURN when eret=1.
REQ-028 RETURN lasts exactly 1 cycle: INT_Return=1, pc_redirect=1, pc_target=epc, in_service=1; next state is IDLE.
REQ-029 In RETURN, int_cause is retained.
REQ-030 A pending interrupt may be accepted in the first IDLE cycle after RETURN, giving a minimum 1-cycle IDLE gap between INT_Return and the next INT_Detect.
REQ-031 Latency: irq rises in cycle 0 -> pending=1 in cycle 1 -> INT_Detect=1 in cycle 2 (with int_en=1 and stall=0 in cycle 1).
REQ-032 pc_target shall be 0 whenever pc_redirect=0.
REQ-033 INT_Detect and INT_Return shall never be high in the same cycle.

Reset
REQ-034 When Rst=1 at a clock edge: state <= IDLE; pending, irq_prev, epc and int_cause <= 0; all outputs 0 in the following cycle.
REQ-035 Reset has priority over every event, including reset during DETECT, SERVICE or RETURN; no INT_Return pulse is issued afterwards.
REQ-036 Because irq_prev resets to 0, an irq line held high through reset registers one edge in the first cycle after reset.

Verification
REQ-037 Single interrupt: irq[2] rises in cycle 0 with pc_cur=32'h0000_0040 in cycle 1 -> INT_Detect=1 in cycle 2, pc_target=32'h0000_0120, int_cause=2, epc=32'h0000_0040.
REQ-038 Return path: eret=1 for 1 cycle in SERVICE -> next cycle INT_Return=1, pc_redirect=1, pc_target=32'h0000_0040; following cycle IDLE with all pulses 0.
REQ-039 Priority and no nesting: irq[3] and irq[1] rise together -> cause 1 serviced first; irq[0] rising during SERVICE is not taken until RETURN -> IDLE; then cause 0, then cause 3.
REQ-040 Gating: pending set with int_en=0 or stall=1 -> no INT_Detect; INT_Detect occurs 1 cycle after the gate clears.
REQ-041 Mid-service reset: Rst=1 in SERVICE -> all outputs 0 and pending=0 next cycle; irq held high -> a new INT_Detect is produced 2 cycles after Rst falls.
REQ-042 Collision: a new edge on irq[1] in the acceptance cycle of source 1 -> source 1 is serviced twice.

Source files
------------

// File: rtl/int_ctrl.sv
// Single-level interrupt controller: edge-captures four request lines, accepts the
// highest-priority pending source, and sequences detect/service/return with PC redirects.
module int_ctrl #(
  parameter logic [31:0] VEC_BASE = 32'h0000_0100,
  parameter int          NSRC     = 4
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic [NSRC-1:0] irq,
  input  logic            int_en,
  input  logic            stall,
  input  logic [31:0]     pc_cur,
  input  logic            eret,
  output logic            INT_Detect,
  output logic            INT_Return,
  output logic            pc_redirect,
  output logic [31:0]     pc_target,
  output logic [31:0]     epc,
  output logic [1:0]      int_cause,
  output logic            in_service
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DETECT  = 2'd1,
    ST_SERVICE = 2'd2,
    ST_RETURN  = 2'd3
  } state_t;

  // Bit 0 is the highest priority, so the lowest set index wins.
  function automatic logic [1:0] f_lowest_set(input logic [NSRC-1:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = i[1:0];
      end
    end
    return idx;
  endfunction

  state_t            r_state;
  state_t            w_state_nxt;
  logic [NSRC-1:0]   r_irq_prev;
  logic [NSRC-1:0]   r_pending;
  logic [31:0]       r_epc;
  logic [1:0]        r_int_cause;

  logic              w_accept;
  logic [1:0]        w_sel;
  logic [NSRC-1:0]   w_edge;
  logic [NSRC-1:0]   w_accept_mask;

  assign w_edge        = irq & ~r_irq_prev;
  assign w_sel         = f_lowest_set(r_pending);
  assign w_accept_mask = w_accept ? ({{(NSRC-1){1'b0}}, 1'b1} << w_sel) : {NSRC{1'b0}};

  // Next-state decode; acceptance only ever happens out of IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if ((r_pending != {NSRC{1'b0}}) && int_en && !stall) begin
          w_state_nxt = ST_DETECT;
          w_accept    = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DETECT: begin
        w_state_nxt = ST_SERVICE;
      end
      ST_SERVICE: begin
        if (eret) begin
          w_state_nxt = ST_RETURN;
        end else begin
          w_state_nxt = ST_SERVICE;
        end
      end
      ST_RETURN: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, edge history, sticky pending bits and the saved context.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state     <= ST_IDLE;
      r_irq_prev  <= {NSRC{1'b0}};
      r_pending   <= {NSRC{1'b0}};
      r_epc       <= 32'h0000_0000;
      r_int_cause <= 2'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_irq_prev <= irq;
      // A fresh edge overrides the clear of the source being accepted.
      r_pending  <= (r_pending & ~w_accept_mask) | w_edge;
      if (w_accept) begin
        r_int_cause <= w_sel;
        r_epc       <= pc_cur;
      end
    end
  end

  // Outputs decode from the state register and saved context only.
  always_comb begin
    INT_Detect  = 1'b0;
    INT_Return  = 1'b0;
    pc_redirect = 1'b0;
    pc_target   = 32'h0000_0000;
    in_service  = 1'b0;
    case (r_state)
      ST_DETECT: begin
        INT_Detect  = 1'b1;
        pc_redirect = 1'b1;
        pc_target   = VEC_BASE + {26'd0, r_int_cause, 4'b0000};
      end
      ST_SERVICE: begin
        in_service = 1'b1;
      end
      ST_RETURN: begin
        INT_Return  = 1'b1;
        pc_redirect = 1'b1;
        pc_target   = r_epc;
        in_service  = 1'b1;
      end
      default: begin
        in_service = 1'b0;
      end
    endcase
  end

  assign epc       = r_epc;
  assign int_cause = r_int_cause;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed self-checking bench for int_ctrl; outputs are compared as one packed word
// {INT_Detect, INT_Return, pc_redirect, in_service, int_cause, pc_target, epc}.
module tb_int_ctrl;

  logic        Clk;
  logic        Rst;
  logic [3:0]  irq;
  logic        int_en;
  logic        stall;
  logic [31:0] pc_cur;
  logic        eret;
  logic        INT_Detect;
  logic        INT_Return;
  logic        pc_redirect;
  logic [31:0] pc_target;
  logic [31:0] epc;
  logic [1:0]  int_cause;
  logic        in_service;

  logic [69:0] w_obs;
  logic [69:0] exp_v;
  int          pass_cnt;
  int          total_cnt;

  int_ctrl #(.VEC_BASE(32'h0000_0100), .NSRC(4)) dut (
    .Clk(Clk), .Rst(Rst), .irq(irq), .int_en(int_en), .stall(stall),
    .pc_cur(pc_cur), .eret(eret), .INT_Detect(INT_Detect), .INT_Return(INT_Return),
    .pc_redirect(pc_redirect), .pc_target(pc_target), .epc(epc),
    .int_cause(int_cause), .in_service(in_service)
  );

  assign w_obs = {INT_Detect, INT_Return, pc_redirect, in_service, int_cause, pc_target, epc};

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Rst = 1'b1; irq = 4'b0000; int_en = 1'b0; stall = 1'b0; pc_cur = 32'h0; eret = 1'b0;
    step();
    step();
    exp_v = 70'd0;
    total_cnt++;
    if (w_obs !== exp_v) $display("FAIL reset_outputs: got %h expected %h", w_obs, exp_v); else pass_cnt++;
    total_cnt++;
    if (dut.r_pending !== 4'b0000) $display("FAIL reset_pending: got %b expected 0000", dut.r_pending); else pass_cnt++;
    Rst = 1'b0;
    int_en = 1'b1;
    step();
  endtask

  task automatic test_single();
    irq = 4'b0100;
    step();
    total_cnt++;
    if (dut.r_pending !== 4'b0100 || INT_Detect !== 1'b0)
      $display("FAIL single_pending: got pending=%b det=%b expected 0100/0", dut.r_pending, INT_Detect);
    else pass_cnt++;
    pc_cur = 32'h0000_0040;
    step();
    exp_v = {1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 32'h0000_0120, 32'h0000_0040};
    total_cnt++;
    if (w_obs !== exp_v) $display("FAIL single_detect: got %h expected %h", w_obs, exp_v); else pass_cnt++;
    step();
    exp_v = {1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 32'h0, 32'h0000_0040};
    total_cnt++;
    if (w_obs !== exp_v) $display("FAIL single_service: got %h expected %h", w_obs, exp_v); else pass_cnt++;
    eret = 1'b1;
    step();
    eret = 1'b0;
    exp_v = {1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 32'h0000_0040, 32'h0000_0040};
    total_cnt++;
    if (w_obs !== exp_v) $display("FAIL single_return: got %h expected %h", w_obs, exp_v); else pass_cnt++;
    step();
    exp_v = {1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 32'h0, 32'h0000_0040};
    total_cnt++;
    if (w_obs !== exp_v) $display("FAIL single_idle: got %h expected %h", w_obs, exp_v); else pass_cnt++;
    irq = 4'b0000;
    step();
  endtask

  task automatic test_priority();
    irq = 4'b1010;
    step();
    pc_cur = 32'h0000_0200;
    step();
    exp_v = {1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 32'h0000_0110, 32'h0000_0200};
    total_cnt++;
    if (w_obs !== exp_v) $display("FAIL prio_first_cause1: got %h expected %h", w_obs, exp_v); else pass_cnt++;
    step();
    irq = 4'b1011;
    step();
    exp_v = {1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 32'h0, 32'h0000_0200};
    total_cnt++;
    if (w_obs !== exp_v || dut.r_pending !== 4'b1001)
      $display("FAIL prio_no_nest: got %h pending=%b expected %h pending=1001", w_obs, dut.r_pending, exp_v);
    else pass_cnt++;
    eret = 1'b1;
    step();
    eret = 1'b0;
    step();
    exp_v = {1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 32'h0, 32'h0000_0200};
    total_cnt++;
    if (w_obs !== exp_v) $display("FAIL prio_idle_gap: got %h expected %h", w_obs, exp_v); else pass_cnt++;
    pc_cur = 32'h0000_0300;
    step();
    exp_v = {1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0000_0100, 32'h0000_0300};
    total_cnt++;
    if (w_obs !== exp_v) $display("FAIL prio_second_cause0: got %h expected %h", w_obs, exp_v); else pass_cnt++;
    step();
    eret = 1'b1;
    step();
    eret = 1'b0;
    step();
    pc_cur = 32'h0000_0400;
    step();
    exp_v = {1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 32'h0000_0130, 32'h0000_0400};
    total_cnt++;
    if (w_obs !== exp_v) $display("FAIL prio_third_cause3: got %h expected %h", w_obs, exp_v); else pass_cnt++;
    step();
    eret = 1'b1;
    step();
    eret = 1'b0;
    step();
    irq = 4'b0000;
    step();
  endtask

  task automatic test_gating();
    int_en = 1'b0;
    irq = 4'b0001;
    step();
    step();
    step();
    exp_v = {1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 32'h0, 32'h0000_0400};
    total_cnt++;
    if (w_obs !== exp_v) $display("FAIL gate_int_en: got %h expected %h", w_obs, exp_v); else pass_cnt++;
    int_en = 1'b1;
    stall = 1'b1;
    step();
    total_cnt++;
    if (w_obs !== exp_v) $display("FAIL gate_stall: got %h expected %h", w_obs, exp_v); else pass_cnt++;
    stall = 1'b0;
    pc_cur = 32'h0000_0500;
    step();
    exp_v = {1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0000_0100, 32'h0000_0500};
    total_cnt++;
    if (w_obs !== exp_v) $display("FAIL gate_release: got %h expected %h", w_obs, exp_v); else pass_cnt++;
    step();
    eret = 1'b1;
    step();
    eret = 1'b0;
    step();
    irq = 4'b0000;
    step();
  endtask

  task automatic test_mid_reset();
    irq = 4'b0100;
    step();
    pc_cur = 32'h0000_0600;
    step();
    step();
    total_cnt++;
    if (in_service !== 1'b1) $display("FAIL midrst_in_service: got %b expected 1", in_service); else pass_cnt++;
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    exp_v = 70'd0;
    total_cnt++;
    if (w_obs !== exp_v || dut.r_pending !== 4'b0000)
      $display("FAIL midrst_cleared: got %h pending=%b expected %h pending=0000", w_obs, dut.r_pending, exp_v);
    else pass_cnt++;
    step();
    total_cnt++;
    if (w_obs !== exp_v || dut.r_pending !== 4'b0100)
      $display("FAIL midrst_reedge: got %h pending=%b expected %h pending=0100", w_obs, dut.r_pending, exp_v);
    else pass_cnt++;
    step();
    exp_v = {1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 32'h0000_0120, 32'h0000_0600};
    total_cnt++;
    if (w_obs !== exp_v) $display("FAIL midrst_redetect: got %h expected %h", w_obs, exp_v); else pass_cnt++;
    step();
    eret = 1'b1;
    step();
    eret = 1'b0;
    step();
    irq = 4'b0000;
    step();
  endtask

  task automatic test_collision();
    irq = 4'b0010;
    stall = 1'b1;
    step();
    irq = 4'b0000;
    step();
    irq = 4'b0010;
    stall = 1'b0;
    pc_cur = 32'h0000_0700;
    step();
    exp_v = {1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 32'h0000_0110, 32'h0000_0700};
    total_cnt++;
    if (w_obs !== exp_v || dut.r_pending !== 4'b0010)
      $display("FAIL collide_first: got %h pending=%b expected %h pending=0010", w_obs, dut.r_pending, exp_v);
    else pass_cnt++;
    step();
    eret = 1'b1;
    step();
    eret = 1'b0;
    step();
    pc_cur = 32'h0000_0800;
    step();
    exp_v = {1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 32'h0000_0110, 32'h0000_0800};
    total_cnt++;
    if (w_obs !== exp_v) $display("FAIL collide_second: got %h expected %h", w_obs, exp_v); else pass_cnt++;
    step();
    eret = 1'b1;
    step();
    eret = 1'b0;
    irq = 4'b0000;
    step();
    total_cnt++;
    if (dut.r_pending !== 4'b0000 || INT_Detect !== 1'b0)
      $display("FAIL collide_drained: got pending=%b det=%b expected 0000/0", dut.r_pending, INT_Detect);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_single();
    test_priority();
    test_gating();
    test_mid_reset();
    test_collision();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
